// File: rtl/seg_pkg.sv
// Shared 7-segment display definitions: slot type, blank/dash patterns, digit table.
// leading_zero() backs the optional LEADING_ZERO_BLANK_EN build of seg_scan_ctrl.
package seg_pkg;

    typedef logic [1:0] slot_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Active-low g..a patterns for digits 9 down to 0, packed so DIGIT_SEG[d] is digit d.
    localparam logic [9:0][6:0] DIGIT_SEG = {
        7'b0010000,
        7'b0000000,
        7'b1111000,
        7'b0000010,
        7'b0010010,
        7'b0011001,
        7'b0110000,
        7'b0100100,
        7'b1111001,
        7'b1000000
    };

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] pattern;
        if (d > 4'd9) begin
            pattern = SEG_DASH;
        end else begin
            pattern = DIGIT_SEG[d];
        end
        return pattern;
    endfunction

    // True when digit s and every digit above it are zero; digit 0 never qualifies.
    function automatic logic leading_zero(input logic [15:0] digits, input slot_t s);
        logic lz;
        case (s)
            2'd3:    lz = (digits[15:12] == 4'd0);
            2'd2:    lz = (digits[15:8] == 8'd0);
            2'd1:    lz = (digits[15:4] == 12'd0);
            default: lz = 1'b0;
        endcase
        return lz;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_tick_div.sv
// Enabled modulo-DIV counter: tick is high for one cycle every DIV enabled cycles.
// The count holds while en is low, so a paused scan resumes exactly where it stopped.
module tick_div #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt;

    assign tick = en && (cnt == W'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            if (tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + W'(1);
            end
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit common-anode 7-segment scan controller with per-frame input snapshot and blink.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int SCAN_DIV  = 100_000,
    parameter int BLINK_DIV = 50_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] bcd_in,
    input  logic [3:0]  blink_mask,
    input  logic [3:0]  dp_in,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_done
);
    logic        scan_tick;
    logic        blink_tick;
    logic        wrap;
    logic        blink_phase;
    slot_t       slot;
    logic [15:0] shadow_bcd;
    logic [3:0]  shadow_blink;
    logic [3:0]  shadow_dp;
    logic [3:0]  cur_digit;
    logic        zero_blank;
    logic        blanked;
    logic [6:0]  next_seg;
    logic        next_dp;
    logic [3:0]  next_an;

    tick_div #(.DIV(SCAN_DIV)) u_scan_div (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .tick (scan_tick)
    );

    tick_div #(.DIV(BLINK_DIV)) u_blink_div (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (1'b1),
        .tick (blink_tick)
    );

    assign wrap = scan_tick && (slot == 2'd3);

    always_comb begin
        cur_digit = shadow_bcd[{slot, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        zero_blank = leading_zero(shadow_bcd, slot);
`else
        zero_blank = 1'b0;
`endif
        blanked  = (shadow_blink[slot] && blink_phase) || zero_blank;
        next_seg = blanked ? SEG_BLANK : bcd_to_seg(cur_digit);
        next_dp  = blanked ? 1'b1 : ~shadow_dp[slot];
        next_an  = ~(4'b0001 << slot);
    end

    // Slot rotation, blink phase and the frame snapshot taken on the 3->0 wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot         <= 2'd0;
            blink_phase  <= 1'b0;
            shadow_bcd   <= '0;
            shadow_blink <= '0;
            shadow_dp    <= '0;
        end else begin
            if (scan_tick) begin
                slot <= slot + 2'd1;
            end
            if (blink_tick) begin
                blink_phase <= ~blink_phase;
            end
            if (wrap) begin
                shadow_bcd   <= bcd_in;
                shadow_blink <= blink_mask;
                shadow_dp    <= dp_in;
            end
        end
    end

    // The slot-advance cycle drives all anodes off so the old digit never ghosts onto the next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an         <= 4'b1111;
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else if (!en) begin
            an         <= 4'b1111;
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            an         <= scan_tick ? 4'b1111 : next_an;
            seg        <= next_seg;
            dp         <= next_dp;
            frame_done <= wrap;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (SCAN_DIV=4, BLINK_DIV=32): per-slot expectations are
// queued as inputs are driven and popped when each new digit slot lights up.
module tb_seg_scan_ctrl;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       blinkable;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] bcd_in;
    logic [3:0]  blink_mask;
    logic [3:0]  dp_in;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    int   total = 0;
    int   bad = 0;
    int   ecount = 0;
    bit   mon_on = 0;
    logic [3:0] prev_lit = 4'hF;
    exp_t sb[$];
    exp_t mon_e;
    logic [6:0] mon_seg;
    logic       mon_dp;

    logic [15:0] t_bcd  [9];
    logic [3:0]  t_mask [9];
    logic [3:0]  t_dp   [9];

    seg_scan_ctrl #(.SCAN_DIV(4), .BLINK_DIV(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .bcd_in    (bcd_in),
        .blink_mask(blink_mask),
        .dp_in     (dp_in),
        .seg       (seg),
        .dp        (dp),
        .an        (an),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] dec(input logic [3:0] d);
        logic [6:0] r;
        case (d)
            4'd0:    r = 7'b1000000;
            4'd1:    r = 7'b1111001;
            4'd2:    r = 7'b0100100;
            4'd3:    r = 7'b0110000;
            4'd4:    r = 7'b0011001;
            4'd5:    r = 7'b0010010;
            4'd6:    r = 7'b0000010;
            4'd7:    r = 7'b1111000;
            4'd8:    r = 7'b0000000;
            4'd9:    r = 7'b0010000;
            default: r = 7'b0111111;
        endcase
        return r;
    endfunction

    function automatic exp_t make_exp(input logic [15:0] bcd, input logic [3:0] mask,
                                      input logic [3:0] dpv, input int s);
        exp_t e;
        logic [15:0] sh;
        sh = bcd >> (4 * s);
        e.an = 4'b1111;
        e.an[s] = 1'b0;
        e.seg = dec(sh[3:0]);
        e.dp = ~dpv[s];
        e.blinkable = mask[s];
`ifdef LEADING_ZERO_BLANK_EN
        if (s > 0 && sh == 16'h0000) begin
            e.seg = 7'h7F;
            e.dp = 1'b1;
        end
`endif
        return e;
    endfunction

    task automatic push_frame(input logic [15:0] bcd, input logic [3:0] mask, input logic [3:0] dpv);
        for (int s = 0; s < 4; s++) begin
            sb.push_back(make_exp(bcd, mask, dpv, s));
        end
    endtask

    // Drive table entry k; it is snapshotted at the next wrap, so it shows one frame later.
    task automatic applyStimulus(input int k);
        bcd_in = t_bcd[k];
        blink_mask = t_mask[k];
        dp_in = t_dp[k];
        push_frame(t_bcd[k], t_mask[k], t_dp[k]);
    endtask

    task automatic wait_frame(output bit found);
        found = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                found = 1;
                break;
            end
        end
    endtask

    task automatic wait_an(input logic [3:0] target, output bit found);
        found = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (an === target) begin
                found = 1;
                break;
            end
        end
    endtask

    always @(posedge clk) begin
        if (mon_on) ecount++;
    end

    // A new slot is detected when the lit anode differs from the last lit anode.
    always @(negedge clk) begin
        if (mon_on && an !== 4'hF && an !== prev_lit) begin
            prev_lit = an;
            if (sb.size() == 0) begin
                checkOutput("sb_underflow", 16'(an), 16'hF);
            end else begin
                mon_e = sb.pop_front();
                mon_seg = mon_e.seg;
                mon_dp = mon_e.dp;
                if (mon_e.blinkable && (((ecount - 1) / 32) % 2 == 1)) begin
                    mon_seg = 7'h7F;
                    mon_dp = 1'b1;
                end
                checkOutput("slot_an", 16'(an), 16'(mon_e.an));
                checkOutput("slot_seg", 16'(seg), 16'(mon_seg));
                checkOutput("slot_dp", 16'(dp), 16'(mon_dp));
            end
        end
    end

    initial begin
        bit found;
        logic [3:0] exp_an;

        t_bcd[0] = 16'h1234; t_mask[0] = 4'b0000; t_dp[0] = 4'b0000;
        t_bcd[1] = 16'h5678; t_mask[1] = 4'b0000; t_dp[1] = 4'b0010;
        t_bcd[2] = 16'h1234; t_mask[2] = 4'b0001; t_dp[2] = 4'b0000;
        t_bcd[3] = 16'h1234; t_mask[3] = 4'b0001; t_dp[3] = 4'b0000;
        t_bcd[4] = 16'h1234; t_mask[4] = 4'b0001; t_dp[4] = 4'b0000;
        t_bcd[5] = 16'h00A0; t_mask[5] = 4'b0000; t_dp[5] = 4'b0000;
        t_bcd[6] = 16'h0050; t_mask[6] = 4'b0000; t_dp[6] = 4'b0000;
        t_bcd[7] = 16'h0000; t_mask[7] = 4'b0000; t_dp[7] = 4'b1111;
        t_bcd[8] = 16'h9876; t_mask[8] = 4'b1111; t_dp[8] = 4'b0100;

        rst_n = 1'b0;
        en = 1'b0;
        bcd_in = '0;
        blink_mask = '0;
        dp_in = '0;
        repeat (3) @(negedge clk);

        // Run briefly, then pull reset asynchronously between clock edges.
        rst_n = 1'b1;
        en = 1'b1;
        bcd_in = 16'h1234;
        repeat (6) @(negedge clk);
        checkOutput("pre_reset_an", 16'(an), 16'h000D);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_an", 16'(an), 16'h000F);
        checkOutput("rst_seg", 16'(seg), 16'h007F);
        checkOutput("rst_dp", 16'(dp), 16'h0001);
        checkOutput("rst_frame_done", 16'(frame_done), 16'h0000);
        @(negedge clk);
        checkOutput("rst_hold_an", 16'(an), 16'h000F);

        // Frame 0 shows the zeroed shadow registers; frame 1 shows table entry 0.
        sb.delete();
        push_frame(16'h0000, 4'b0000, 4'b0000);
        applyStimulus(0);
        prev_lit = 4'hF;
        ecount = 0;
        mon_on = 1;
        rst_n = 1'b1;

        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            exp_an = 4'b1111;
            if ((c - 1) % 4 != 3) exp_an[(c - 1) / 4] = 1'b0;
            checkOutput("seq_an", 16'(an), 16'(exp_an));
            checkOutput("seq_frame_done", 16'(frame_done), (c == 16) ? 16'h1 : 16'h0);
        end

        for (int k = 1; k <= 8; k++) begin
            if (k > 1) begin
                wait_frame(found);
                checkOutput("frame_done_seen", 16'(found), 16'h1);
                if (k == 2) checkOutput("frame_period", 16'(ecount), 16'd32);
            end
            if (k == 1) begin
                wait_an(4'b1101, found);
                checkOutput("midframe_slot1_seen", 16'(found), 16'h1);
            end
            applyStimulus(k);
            if (k == 6) begin
                wait_an(4'b1011, found);
                checkOutput("pause_slot2_seen", 16'(found), 16'h1);
                en = 1'b0;
                repeat (6) begin
                    @(negedge clk);
                    checkOutput("pause_an", 16'(an), 16'h000F);
                    checkOutput("pause_seg", 16'(seg), 16'h007F);
                    checkOutput("pause_dp", 16'(dp), 16'h0001);
                    checkOutput("pause_frame_done", 16'(frame_done), 16'h0000);
                end
                en = 1'b1;
                @(negedge clk);
                checkOutput("resume_an", 16'(an), 16'h000B);
            end
        end

        for (int i = 0; i < 80; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        checkOutput("sb_drain", 16'(sb.size()), 16'h0000);
        mon_on = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
